hiz_tile_ctrl: RTL and testbench

HIZ_TILE_CTRL -- requirements
Module: hiz_tile_ctrl

---
 rtl/hiz_pkg.sv | 21 ++
 rtl/hiz_tile_cmp.sv | 35 +++
 rtl/hiz_tile_ctrl.sv | 133 +++++++++++++
 tb/tb_hiz_tile_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hiz_pkg.sv
// Purpose: shared types and default sizing for the Hi-Z tile controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hiz_pkg;

  localparam int HIZ_PIXELS  = 16;
  localparam int HIZ_DEPTH_W = 24;
  localparam int HIZ_TILES   = 64;

  // CLEAR sweeps the zmax table; IDLE serves queries and updates.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } hiz_state_t;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hiz_tile_cmp.sv
// Purpose: compares every fragment depth of a tile query against the tile zmax.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
//
// Ports: frag_vec (PIXELS packed depths), cov (coverage), zmax (tile zmax),
//        pass_mask (covered and in front), rej_cnt (covered and occluded count).
module hiz_tile_cmp
  import hiz_pkg::*;
#(
  parameter int PIXELS  = HIZ_PIXELS,
  parameter int DEPTH_W = HIZ_DEPTH_W,
  parameter int CNT_W   = $clog2(HIZ_PIXELS + 1)
) (
  input  logic [PIXELS*DEPTH_W-1:0] frag_vec,
  input  logic [PIXELS-1:0]         cov,
  input  logic [DEPTH_W-1:0]        zmax,
  output logic [PIXELS-1:0]         pass_mask,
  output logic [CNT_W-1:0]          rej_cnt
);

  logic occ;

  always_comb begin
    pass_mask = '0;
    rej_cnt   = '0;
    occ       = 1'b0;
    for (int i = 0; i < PIXELS; i++) begin
      // Equal depth counts as occluded: zmax is the farthest surface already drawn.
      occ          = (frag_vec[i*DEPTH_W +: DEPTH_W] >= zmax);
      pass_mask[i] = cov[i] & ~occ;
      rej_cnt      = rej_cnt + CNT_W'(cov[i] & occ);
    end
  end

endmodule

// File: rtl/hiz_tile_ctrl.sv
// Purpose: hierarchical-Z tile reject: per-tile zmax table, query compare, clear sweep.
// Latency: 1 cycle from query accept to r_valid.
// Backpressure: q_ready drops while a result is stalled on r_ready or the table is clearing;
//               u_ready drops only while clearing.
//
// Ports: clk/rst_n; q_* query in (tile, depths, coverage); r_* result out (tile,
//        pass mask, all-reject); u_* zmax update in; clr_start/clr_busy table
//        clear; rej_count running count of rejected covered pixels.
module hiz_tile_ctrl
  import hiz_pkg::*;
#(
  parameter int PIXELS  = HIZ_PIXELS,
  parameter int DEPTH_W = HIZ_DEPTH_W,
  parameter int TILES   = HIZ_TILES,
  localparam int TILE_AW = $clog2(TILES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      q_valid,
  output logic                      q_ready,
  input  logic [TILE_AW-1:0]        q_tile,
  input  logic [PIXELS*DEPTH_W-1:0] q_frag_vec,
  input  logic [PIXELS-1:0]         q_cov,
  output logic                      r_valid,
  input  logic                      r_ready,
  output logic [TILE_AW-1:0]        r_tile,
  output logic [PIXELS-1:0]         r_pass_mask,
  output logic                      r_all_reject,
  input  logic                      u_valid,
  output logic                      u_ready,
  input  logic [TILE_AW-1:0]        u_tile,
  input  logic [DEPTH_W-1:0]        u_zmax,
  input  logic                      clr_start,
  output logic                      clr_busy,
  output logic [31:0]               rej_count
);

  localparam int CNT_W = cnt_w(PIXELS);

  hiz_state_t           state;
  logic [TILE_AW-1:0]   clr_idx;
  logic [DEPTH_W-1:0]   zmax_tbl [TILES];

  logic                 q_acc;
  logic                 u_acc;
  logic [DEPTH_W-1:0]   zmax_eff;
  logic [PIXELS-1:0]    pass_mask;
  logic [CNT_W-1:0]     rej_cnt;

  assign u_ready = (state == ST_IDLE);
  assign q_ready = (state == ST_IDLE) && (!r_valid || r_ready);
  assign q_acc   = q_valid && q_ready;
  assign u_acc   = u_valid && u_ready;

  // Write-first bypass: an update landing on the queried tile this cycle wins.
  assign zmax_eff = (u_acc && (u_tile == q_tile)) ? u_zmax : zmax_tbl[q_tile];

  hiz_tile_cmp #(
    .PIXELS  (PIXELS),
    .DEPTH_W (DEPTH_W),
    .CNT_W   (CNT_W)
  ) u_cmp (
    .frag_vec  (q_frag_vec),
    .cov       (q_cov),
    .zmax      (zmax_eff),
    .pass_mask (pass_mask),
    .rej_cnt   (rej_cnt)
  );

  // Clear sweep / idle control.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_CLEAR;
      clr_idx  <= '0;
      clr_busy <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (clr_idx == TILE_AW'(TILES - 1)) begin
            state    <= ST_IDLE;
            clr_idx  <= '0;
            clr_busy <= 1'b0;
          end else begin
            clr_idx  <= clr_idx + 1'b1;
          end
        end
        ST_IDLE: begin
          if (clr_start) begin
            state    <= ST_CLEAR;
            clr_idx  <= '0;
            clr_busy <= 1'b1;
          end
        end
        default: begin
          state    <= ST_CLEAR;
          clr_idx  <= '0;
          clr_busy <= 1'b1;
        end
      endcase
    end
  end

  // Table storage needs no reset: every reset enters CLEAR and rewrites all entries.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      zmax_tbl[clr_idx] <= '1;
    end else if (u_acc) begin
      zmax_tbl[u_tile] <= u_zmax;
    end
  end

  // Result register and reject counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_tile       <= '0;
      r_pass_mask  <= '0;
      r_all_reject <= 1'b0;
      rej_count    <= '0;
    end else begin
      if (q_acc) begin
        r_valid      <= 1'b1;
        r_tile       <= q_tile;
        r_pass_mask  <= pass_mask;
        r_all_reject <= (pass_mask == '0);
        rej_count    <= rej_count + 32'(rej_cnt);
      end else if (r_ready) begin
        r_valid      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hiz_tile_ctrl.sv
// Purpose: scoreboard bench for hiz_tile_ctrl against a per-pixel reference model.
// Latency: n/a.
// Backpressure: drives r_ready low in bursts to exercise result stalls.
module tb_hiz_tile_ctrl;

  localparam int PIXELS  = 16;
  localparam int DEPTH_W = 24;
  localparam int TILES   = 64;
  localparam int TILE_AW = 6;
  localparam int FV_W    = PIXELS * DEPTH_W;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                q_valid;
  logic                q_ready;
  logic [TILE_AW-1:0]  q_tile;
  logic [FV_W-1:0]     q_frag_vec;
  logic [PIXELS-1:0]   q_cov;
  logic                r_valid;
  logic                r_ready;
  logic [TILE_AW-1:0]  r_tile;
  logic [PIXELS-1:0]   r_pass_mask;
  logic                r_all_reject;
  logic                u_valid;
  logic                u_ready;
  logic [TILE_AW-1:0]  u_tile;
  logic [DEPTH_W-1:0]  u_zmax;
  logic                clr_start;
  logic                clr_busy;
  logic [31:0]         rej_count;

  always #5 clk = ~clk;

  hiz_tile_ctrl #(.PIXELS(PIXELS), .DEPTH_W(DEPTH_W), .TILES(TILES)) dut (
    .clk(clk), .rst_n(rst_n),
    .q_valid(q_valid), .q_ready(q_ready), .q_tile(q_tile),
    .q_frag_vec(q_frag_vec), .q_cov(q_cov),
    .r_valid(r_valid), .r_ready(r_ready), .r_tile(r_tile),
    .r_pass_mask(r_pass_mask), .r_all_reject(r_all_reject),
    .u_valid(u_valid), .u_ready(u_ready), .u_tile(u_tile), .u_zmax(u_zmax),
    .clr_start(clr_start), .clr_busy(clr_busy), .rej_count(rej_count)
  );

  typedef struct {
    logic [TILE_AW-1:0] tile;
    logic [PIXELS-1:0]  mask;
    logic               allrej;
    logic [31:0]        rej;
  } exp_t;

  exp_t              sb[$];
  logic [DEPTH_W-1:0] model_tbl [TILES];
  logic [31:0]       model_rej;
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_pop = 0;
  logic [PIXELS-1:0] last_mask;
  logic              last_allrej;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [FV_W-1:0] fill(input logic [DEPTH_W-1:0] ev, input logic [DEPTH_W-1:0] od);
    logic [FV_W-1:0] v;
    v = '0;
    for (int i = 0; i < PIXELS; i++) v[i*DEPTH_W +: DEPTH_W] = (i % 2 == 0) ? ev : od;
    return v;
  endfunction

  function automatic logic [FV_W-1:0] rnd_depths();
    logic [FV_W-1:0] v;
    v = '0;
    for (int i = 0; i < PIXELS; i++) v[i*DEPTH_W +: DEPTH_W] = 24'h7FFFF8 + 24'($urandom_range(0, 16));
    return v;
  endfunction

  // Reference: a covered pixel is rejected when depth >= zmax of its tile.
  task automatic model_query(input logic [TILE_AW-1:0] t, input logic [FV_W-1:0] fv,
                             input logic [PIXELS-1:0] cv, input logic [DEPTH_W-1:0] zm);
    exp_t e;
    int   rej;
    rej    = 0;
    e.mask = '0;
    for (int i = 0; i < PIXELS; i++) begin
      if (cv[i]) begin
        if (fv[i*DEPTH_W +: DEPTH_W] >= zm) rej++;
        else e.mask[i] = 1'b1;
      end
    end
    model_rej = model_rej + 32'(rej);
    e.tile    = t;
    e.allrej  = (e.mask == '0);
    e.rej     = model_rej;
    sb.push_back(e);
  endtask

  // One clock of stimulus; entered and left at posedge+1.
  task automatic cycle(input logic qv, input logic [TILE_AW-1:0] qt, input logic [FV_W-1:0] fv,
                       input logic [PIXELS-1:0] cv, input logic uv, input logic [TILE_AW-1:0] ut,
                       input logic [DEPTH_W-1:0] uz, input logic rr, input logic cs, output logic qa);
    logic ua;
    logic idle;
    q_valid = qv; q_tile = qt; q_frag_vec = fv; q_cov = cv;
    u_valid = uv; u_tile = ut; u_zmax = uz; r_ready = rr; clr_start = cs;
    @(negedge clk);
    qa   = q_valid && q_ready;
    ua   = u_valid && u_ready;
    idle = !clr_busy;
    if (qa) model_query(qt, fv, cv, (ua && ut == qt) ? uz : model_tbl[qt]);
    if (ua) model_tbl[ut] = uz;
    if (cs && idle) for (int i = 0; i < TILES; i++) model_tbl[i] = '1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    logic qa;
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b1, 1'b0, qa);
  endtask

  // Monitor: a result is consumed on the edge following a negedge with valid && ready.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && r_valid === 1'b1 && r_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got tile 0x%0h mask 0x%0h with no result expected", r_tile, r_pass_mask);
        end else begin
          e = sb.pop_front();
          chk("r_tile", r_tile, e.tile);
          chk("r_pass_mask", r_pass_mask, e.mask);
          chk("r_all_reject", r_all_reject, e.allrej);
          chk("rej_count", rej_count, e.rej);
        end
        last_mask   = r_pass_mask;
        last_allrej = r_all_reject;
        n_pop++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic qa;
    int   busy_cnt;
    int   acc_cnt;
    int   pop0;
    logic ready_low;

    rst_n = 1'b0; q_valid = 0; q_tile = '0; q_frag_vec = '0; q_cov = '0;
    r_ready = 1'b1; u_valid = 0; u_tile = '0; u_zmax = '0; clr_start = 0;
    model_rej = '0;
    for (int i = 0; i < TILES; i++) model_tbl[i] = '1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_r_valid", r_valid, 0);
    chk("reset_r_pass_mask", r_pass_mask, 0);
    chk("reset_r_tile", r_tile, 0);
    chk("reset_r_all_reject", r_all_reject, 0);
    chk("reset_rej_count", rej_count, 0);
    chk("reset_clr_busy", clr_busy, 1);

    // Clear sweep after reset release.
    rst_n = 1'b1;
    #1;
    busy_cnt  = 0;
    ready_low = 1'b1;
    while (clr_busy === 1'b1 && busy_cnt < 200) begin
      busy_cnt++;
      if (q_ready !== 1'b0 || u_ready !== 1'b0) ready_low = 1'b0;
      @(negedge clk);
    end
    chk("clear_busy_cycles", busy_cnt, 64);
    chk("clear_ready_low", ready_low, 1);
    chk("idle_q_ready", q_ready, 1);
    chk("idle_u_ready", u_ready, 1);
    @(posedge clk);
    #1;

    // Full reject against a nearer zmax.
    cycle(1'b0, '0, '0, '0, 1'b1, 6'd3, 24'h400000, 1'b1, 1'b0, qa);
    cycle(1'b1, 6'd3, fill(24'h500000, 24'h500000), 16'hFFFF, 1'b0, '0, '0, 1'b1, 1'b0, qa);
    idle_cycle(); idle_cycle();
    chk("far_mask", last_mask, 16'h0000);
    chk("far_all_reject", last_allrej, 1);
    chk("far_rej_count", rej_count, 16);

    // Alternating just-in-front / equal depths.
    cycle(1'b1, 6'd3, fill(24'h3FFFFF, 24'h400000), 16'hFFFF, 1'b0, '0, '0, 1'b1, 1'b0, qa);
    idle_cycle(); idle_cycle();
    chk("alt_mask", last_mask, 16'h5555);
    chk("alt_rej_count", rej_count, 24);

    // Same-cycle update and query to one tile.
    cycle(1'b1, 6'd5, fill(24'h000200, 24'h000200), 16'hFFFF, 1'b1, 6'd5, 24'h000100, 1'b1, 1'b0, qa);
    idle_cycle(); idle_cycle();
    chk("bypass_all_reject", last_allrej, 1);
    chk("bypass_rej_count", rej_count, 40);

    // Result stall then back-to-back throughput.
    cycle(1'b1, 6'd3, fill(24'h3FFFFF, 24'h400000), 16'hFFFF, 1'b0, '0, '0, 1'b0, 1'b0, qa);
    pop0 = n_pop;
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 6'd7, fill(24'h000010, 24'h000010), 16'hFFFF, 1'b0, '0, '0, 1'b0, 1'b0, qa);
      chk("stall_q_accept", qa, 0);
      chk("stall_r_valid", r_valid, 1);
      chk("stall_r_tile", r_tile, 3);
      chk("stall_r_pass_mask", r_pass_mask, 16'h5555);
    end
    acc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 6'($urandom_range(0, 7)), rnd_depths(), 16'($urandom), 1'b0, '0, '0, 1'b1, 1'b0, qa);
      if (qa) acc_cnt++;
    end
    idle_cycle();
    chk("b2b_accepts", acc_cnt, 4);
    chk("b2b_results", n_pop - pop0, 5);

    // Updates, then a clear with a result still pending.
    for (int t = 0; t < 8; t++)
      cycle(1'b0, '0, '0, '0, 1'b1, 6'(t), 24'h000100, 1'b1, 1'b0, qa);
    cycle(1'b1, 6'd0, fill(24'h000080, 24'h000180), 16'hFFFF, 1'b0, '0, '0, 1'b0, 1'b0, qa);
    cycle(1'b0, '0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b1, qa);
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 200) begin
      idle_cycle();
      busy_cnt++;
    end
    chk("clr_done", clr_busy, 0);
    for (int t = 0; t < TILES; t++) begin
      cycle(1'b1, 6'(t), fill(24'hFFFFFE, 24'hFFFFFF), 16'h0003, 1'b0, '0, '0, 1'b1, 1'b0, qa);
      if (!qa) begin
        n_cmp++; n_err++;
        $display("FAIL clr_query_accept: tile %0d not accepted, required accepted", t);
      end
    end
    idle_cycle(); idle_cycle();
    chk("clr_mask", last_mask, 16'h0001);

    // Randomized traffic.
    for (int k = 0; k < 500; k++) begin
      cycle(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), rnd_depths(), 16'($urandom),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 24'h7FFFF8 + 24'($urandom_range(0, 16)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 99) == 0), qa);
    end

    busy_cnt = 0;
    while (sb.size() != 0 && busy_cnt < 200) begin
      idle_cycle();
      busy_cnt++;
    end
    chk("drain_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
